// File: rtl/fcore_instruction_receiver_if.sv
// Valid/ready instruction stream carrying instruction word, channel and PC.
// The master drives the beat; the slave returns ready.
interface fcore_instruction_receiver_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 12
) ();
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (
        output data, dest, user, valid,
        input  ready
    );

    modport slave (
        input  data, dest, user, valid,
        output ready
    );
endinterface

// File: rtl/fcore_instruction_receiver.sv
// fCore instruction receiver: two-entry skid buffer plus field decode.
// Define FCORE_RX_SEQ_CHECK_EN to enable channel/PC sequencing and fault.
module fcore_instruction_receiver #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int OPCODE_WIDTH      = 5,
    parameter int REG_ADDR_WIDTH    = 4,
    parameter int PC_WIDTH          = 12,
    parameter int MAX_CHANNELS      = 255,
    localparam int CW = $clog2(MAX_CHANNELS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CW-1:0]                n_channels,
    fcore_instruction_receiver_if.slave  instruction_stream,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OPCODE_WIDTH-1:0]      out_opcode,
    output logic [REG_ADDR_WIDTH-1:0]    out_op_a,
    output logic [REG_ADDR_WIDTH-1:0]    out_op_b,
    output logic [REG_ADDR_WIDTH-1:0]    out_dest,
    output logic [INSTRUCTION_WIDTH-1:0] out_raw,
    output logic [CW-1:0]                out_channel,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic                         program_done,
    output logic                         fault,
    input  logic                         fault_clear
);

    // STOP encoding of the fCore ISA
    localparam logic [OPCODE_WIDTH-1:0] OP_STOP =
        OPCODE_WIDTH'(12);

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] word;
        logic [CW-1:0]                ch;
        logic [PC_WIDTH-1:0]          pc;
    } beat_t;

    beat_t         in_beat;
    beat_t         out_q;
    beat_t         skid_q;
    logic          out_valid_q;
    logic          skid_full;
    logic          tready_q;
    logic          accept;
    logic          keep;
    logic          out_fire;
    logic          drop_n;
    logic [CW-1:0] last_ch;

    logic          load_in;
    logic          load_skid;
    logic          skid_load;
    logic          out_valid_n;
    logic          skid_full_n;
    logic          tready_n;

    assign in_beat = '{
        word: instruction_stream.data,
        ch:   instruction_stream.dest,
        pc:   instruction_stream.user
    };

    assign instruction_stream.ready = tready_q;

    assign accept   = instruction_stream.valid & tready_q;
    assign out_fire = out_valid_q & out_ready;
    assign last_ch  = (n_channels == '0) ? '0
                    : n_channels - CW'(1);

`ifdef FCORE_RX_SEQ_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FAULT
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CW-1:0]       prev_dest;
    logic [PC_WIDTH-1:0] prev_pc;
    logic [CW-1:0]       dest_inc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                seq_ok;
    logic                in_stop;

    assign dest_inc = prev_dest + CW'(1);
    assign pc_inc   = prev_pc + PC_WIDTH'(1);
    assign in_stop  = in_beat.word[OPCODE_WIDTH-1:0] == OP_STOP;

    always_comb begin
        seq_ok = 1'b0;
        if (state == S_IDLE) begin
            seq_ok = in_beat.ch == '0;
        end else if (prev_dest == last_ch) begin
            seq_ok = (in_beat.ch == '0) &&
                     ((in_beat.pc == prev_pc) ||
                      (in_beat.pc == pc_inc));
        end else begin
            seq_ok = (in_beat.ch == dest_inc) &&
                     (in_beat.pc == prev_pc);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_STREAM: begin
                if (accept) begin
                    if (!seq_ok)
                        state_n = S_FAULT;
                    else if (state == S_STREAM && in_stop &&
                             in_beat.ch == last_ch)
                        state_n = S_IDLE;
                    else
                        state_n = S_STREAM;
                end
            end
            S_FAULT: begin
                if (fault_clear)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Beats arriving in FAULT, or that cause it, never reach the buffer
    assign keep   = accept & (state != S_FAULT) & seq_ok;
    assign drop_n = state_n == S_FAULT;
    assign fault  = state == S_FAULT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            prev_dest <= '0;
            prev_pc   <= '0;
        end else begin
            state <= state_n;
            if (keep) begin
                prev_dest <= in_beat.ch;
                prev_pc   <= in_beat.pc;
            end
        end
    end
`else
    logic unused_fault_clear;

    assign unused_fault_clear = fault_clear;
    assign keep               = accept;
    assign drop_n             = 1'b0;
    assign fault              = 1'b0;
`endif

    always_comb begin
        load_in     = keep &
                      (~out_valid_q | (out_fire & ~skid_full));
        load_skid   = out_fire & skid_full;
        skid_load   = keep & ~load_in;
        out_valid_n = load_in | load_skid |
                      (out_valid_q & ~out_fire);
        skid_full_n = skid_load | (skid_full & ~out_fire);
        tready_n    = ~skid_full_n | drop_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full   <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_n;
            skid_full   <= skid_full_n;
            tready_q    <= tready_n;
            if (load_in)
                out_q <= in_beat;
            else if (load_skid)
                out_q <= skid_q;
            if (skid_load)
                skid_q <= in_beat;
        end
    end

    localparam int R = REG_ADDR_WIDTH;

    assign out_valid   = out_valid_q;
    assign out_raw     = out_q.word;
    assign out_channel = out_q.ch;
    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.word[OPCODE_WIDTH-1:0];
    assign out_op_a    = out_q.word[OPCODE_WIDTH +: R];
    assign out_op_b    = out_q.word[OPCODE_WIDTH+R +: R];
    assign out_dest    = out_q.word[OPCODE_WIDTH+2*R +: R];

    assign program_done = out_fire &&
        (out_q.word[OPCODE_WIDTH-1:0] == OP_STOP) &&
        (out_q.ch == last_ch);

endmodule

// File: tb/tb_fcore_instruction_receiver.sv
// Bench for fcore_instruction_receiver: directed cases then random
// streams checked against a queue-based model of the stream rules.
module tb_fcore_instruction_receiver;

    localparam int IW = 32;
    localparam int PW = 12;
    localparam int CW = 8;
    localparam logic [4:0] STOP = 5'd12;
`ifdef FCORE_RX_SEQ_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] n_channels;
    logic          out_ready;
    logic          fault_clear;
    logic          out_valid;
    logic [4:0]    out_opcode;
    logic [3:0]    out_op_a;
    logic [3:0]    out_op_b;
    logic [3:0]    out_dest;
    logic [IW-1:0] out_raw;
    logic [CW-1:0] out_channel;
    logic [PW-1:0] out_pc;
    logic          program_done;
    logic          fault;

    always #5 clock = ~clock;

    fcore_instruction_receiver_if #(
        .DATA_WIDTH(IW), .DEST_WIDTH(CW), .USER_WIDTH(PW)
    ) strm ();

    fcore_instruction_receiver dut (
        .clock             (clock),
        .reset             (reset),
        .n_channels        (n_channels),
        .instruction_stream(strm),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_opcode        (out_opcode),
        .out_op_a          (out_op_a),
        .out_op_b          (out_op_b),
        .out_dest          (out_dest),
        .out_raw           (out_raw),
        .out_channel       (out_channel),
        .out_pc            (out_pc),
        .program_done      (program_done),
        .fault             (fault),
        .fault_clear       (fault_clear)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  ch;
        logic [11:0] pc;
    } beat_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    beat_t       q[$];
    int          mode = 0;
    logic [7:0]  m_dest = 0;
    logic [11:0] m_pc = 0;
    logic        exp_ready = 1'b0;
    int          stall = 0;
    bit          rnd_rdy = 0;
    bit          saw_low = 0;
    int          n_out = 0;
    int          n_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] last_ch();
        return (n_channels == 0) ? 8'd0 : n_channels - 8'd1;
    endfunction

    function automatic logic [31:0] mkw(input logic [4:0] op);
        logic [31:0] w;
        w = $urandom();
        w[4:0] = op;
        return w;
    endfunction

    function automatic logic [4:0] rand_op();
        logic [4:0] o;
        o = 5'($urandom_range(0, 31));
        if (o == STOP) o = 5'd0;
        return o;
    endfunction

    task automatic model_beat(input beat_t b);
        bit          ok;
        logic [11:0] pinc;
        logic [7:0]  dinc;
        if (mode == 2) return;
        pinc = m_pc + 12'd1;
        dinc = m_dest + 8'd1;
        if (mode == 0)
            ok = (b.ch == 0);
        else if (m_dest == last_ch())
            ok = (b.ch == 0) && (b.pc == m_pc || b.pc == pinc);
        else
            ok = (b.ch == dinc) && (b.pc == m_pc);
        if (!ok && CHECK) begin
            mode = 2;
            return;
        end
        if (mode == 1 && b.d[4:0] == STOP && b.ch == last_ch())
            mode = 0;
        else
            mode = 1;
        m_dest = b.ch;
        m_pc   = b.pc;
        q.push_back(b);
    endtask

    task automatic tick();
        beat_t h;
        bit    xfer;
        bit    acc;
        int    mb;
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (!reset) begin
            q.delete();
            mode = 0;
            exp_ready = 1'b0;
        end
        #1;
        h = '{d: 0, ch: 0, pc: 0};
        chk("ready", strm.ready, exp_ready);
        chk("out_valid", out_valid, q.size() != 0);
        xfer = (q.size() != 0) && out_ready;
        if (q.size() != 0) begin
            h = q[0];
            chk("out_raw", out_raw, h.d);
            chk("out_channel", out_channel, h.ch);
            chk("out_pc", out_pc, h.pc);
            chk("out_opcode", out_opcode, h.d % 32);
            chk("out_op_a", out_op_a, (h.d >> 5) % 16);
            chk("out_op_b", out_op_b, (h.d >> 9) % 16);
            chk("out_dest", out_dest, (h.d >> 13) % 16);
        end
        chk("program_done", program_done,
            xfer && h.d[4:0] == STOP && h.ch == last_ch());
        if (!strm.ready && reset) saw_low = 1;
        if (out_valid && out_ready) n_out++;
        if (program_done) n_done++;
        acc = strm.valid && exp_ready && reset;
        mb = mode;
        @(posedge clock);
        if (reset) begin
            if (xfer) void'(q.pop_front());
            if (acc) model_beat('{d: strm.data, ch: strm.dest,
                                  pc: strm.user});
            if (fault_clear && mb == 2) mode = 0;
            exp_ready = (q.size() < 2) || (mode == 2);
        end
        @(negedge clock);
        chk("fault", fault, mode == 2);
    endtask

    task automatic send(input logic [7:0] ch, input logic [11:0] pc,
                        input logic [4:0] op);
        bit a;
        strm.valid = 1'b1;
        strm.data  = mkw(op);
        strm.dest  = ch;
        strm.user  = pc;
        for (int w = 0; ; w++) begin
            a = exp_ready && reset;
            tick();
            if (a) break;
            if (w > 100) begin
                n_cmp++;
                n_mis++;
                $error("FAIL send_timeout: beat not taken, dest %0d", ch);
                break;
            end
        end
        strm.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        strm.valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        strm.valid = 1'b0;
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        strm.valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic rand_round(input int nb);
        logic [7:0]  d;
        logic [11:0] p;
        logic [4:0]  op;
        for (int i = 0; i < nb; i++) begin
            if (mode != 1) begin
                d = 0;
                p = 12'($urandom);
            end else if (m_dest == last_ch()) begin
                d = 0;
                p = m_pc + 12'($urandom_range(0, 1));
            end else begin
                d = m_dest + 8'd1;
                p = m_pc;
            end
            op = rand_op();
            if (d == last_ch() && $urandom_range(0, 9) == 0) op = STOP;
            if ($urandom_range(0, 24) == 0) d = d + 8'($urandom_range(1, 3));
            if ($urandom_range(0, 24) == 0) p = p + 12'd2;
            fault_clear = (mode == 2) ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 19) == 0);
            send(d, p, op);
            fault_clear = 1'b0;
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        strm.valid  = 1'b0;
        strm.data   = '0;
        strm.dest   = '0;
        strm.user   = '0;
        n_channels  = 8'd3;
        out_ready   = 1'b1;
        fault_clear = 1'b0;

        // reset state
        tick();
        chk("rst_raw", out_raw, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_channel", out_channel, 0);
        chk("rst_opcode", out_opcode, 0);
        tick();
        reset = 1'b1;
        tick();

        // basic stream, out_ready high
        n_out = 0;
        for (int i = 0; i < 6; i++)
            send(8'(i % 3), 12'(i / 3), rand_op());
        drain();
        chk("t1_count", n_out, 6);

        // backpressure after beat 1
        do_reset();
        n_out = 0;
        saw_low = 0;
        send(8'd0, 12'd0, rand_op());
        stall = 4;
        for (int i = 1; i < 6; i++)
            send(8'(i % 3), 12'(i / 3), rand_op());
        drain();
        chk("t2_count", n_out, 6);
        chk("t2_ready_dropped", saw_low, 1);

        // dest skip 0 -> 2, drop, clear together with a beat, resume
        do_reset();
        send(8'd0, 12'd2, rand_op());
        send(8'd2, 12'd2, rand_op());
        send(8'd0, 12'd2, rand_op());
        send(8'd1, 12'd2, rand_op());
        fault_clear = 1'b1;
        send(8'd2, 12'd9, rand_op());
        fault_clear = 1'b0;
        for (int i = 0; i < 3; i++)
            send(8'(i), 12'd7, rand_op());
        drain();

        // pc jump at wrap, then pc wrap 4095 -> 0
        do_reset();
        n_channels = 8'd2;
        send(8'd0, 12'd3, rand_op());
        send(8'd1, 12'd3, rand_op());
        send(8'd0, 12'd5, rand_op());
        send(8'd1, 12'd5, rand_op());
        fault_clear = 1'b1;
        idle(1);
        fault_clear = 1'b0;
        send(8'd0, 12'd4095, rand_op());
        send(8'd1, 12'd4095, rand_op());
        send(8'd0, 12'd0, rand_op());
        send(8'd1, 12'd0, rand_op());
        drain();

        // STOP on last channel, next program restarts at dest 0
        do_reset();
        n_channels = 8'd3;
        n_done = 0;
        send(8'd0, 12'd10, rand_op());
        send(8'd1, 12'd10, rand_op());
        stall = 2;
        send(8'd2, 12'd10, STOP);
        send(8'd0, 12'd77, rand_op());
        send(8'd1, 12'd77, rand_op());
        send(8'd2, 12'd77, rand_op());
        drain();
        chk("t5_done_count", n_done, 1);

        // n_channels = 0 behaves as one channel
        do_reset();
        n_channels = 8'd0;
        n_out = 0;
        for (int i = 0; i < 6; i++)
            send(8'd0, 12'(100 + i), rand_op());
        drain();
        chk("t6_count", n_out, 6);

        // reset with a STOP beat buffered: no program_done
        do_reset();
        n_channels = 8'd1;
        n_done = 0;
        stall = 20;
        send(8'd0, 12'd0, rand_op());
        send(8'd0, 12'd0, STOP);
        stall = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle(3);
        chk("t7_no_done", n_done, 0);

        // random streams
        rnd_rdy = 1;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n_channels = 8'($urandom_range(0, 5));
            rand_round(150);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fcore_instruction_receiver.md
# fcore_instruction_receiver

Consumer end of the fCore instruction stream: accepts the per-channel instruction beats issued by the fCore control unit (data = instruction, dest = channel address, user = program counter), buffers them through a two-entry skid stage, decodes opcode and register fields, and presents them to the execution slice under a valid/ready handshake. It also enforces channel/PC sequencing on the stream, latching a sticky fault on any violation, and flags end of program when a STOP opcode is decoded.

## Interface
- INSTRUCTION_WIDTH, 32, instruction beat width
- OPCODE_WIDTH, 5, opcode field width, bits [OPCODE_WIDTH-1:0]
- REG_ADDR_WIDTH, 4, width of each register-address field
- PC_WIDTH, 12, program counter width carried on user
- MAX_CHANNELS, 255, channel count bound; channel width CW = $clog2(MAX_CHANNELS)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- n_channels  in  CW  active channel count; 0 treated as 1
- instruction_stream  axi_stream.slave  —  data INSTRUCTION_WIDTH, dest CW, user PC_WIDTH, valid/ready
- out_valid  out  1  decoded beat available
- out_ready  in  1  downstream accepts decoded beat
- out_opcode  out  OPCODE_WIDTH  opcode field
- out_op_a  out  REG_ADDR_WIDTH  bits [OPCODE_WIDTH +: R]
- out_op_b  out  REG_ADDR_WIDTH  bits [OPCODE_WIDTH+R +: R]
- out_dest  out  REG_ADDR_WIDTH  bits [OPCODE_WIDTH+2R +: R]
- out_raw  out  INSTRUCTION_WIDTH  full instruction word
- out_channel  out  CW  beat dest
- out_pc  out  PC_WIDTH  beat user
- program_done  out  1  one-cycle pulse when a STOP beat is transferred out on channel n_channels-1
- fault  out  1  sticky sequence fault
- fault_clear  in  1  clears fault, returns to IDLE

## Operation
- Storage: output register (OUT) plus one skid register (SKID). tready = SKID empty, registered.
- Beat accepted (valid & ready): goes to OUT if OUT empty or OUT transferring this cycle; otherwise to SKID. On OUT transfer with SKID full, SKID moves to OUT.
- Decode is pure field slicing of the buffered word; no arithmetic.
- Sequencer states:
  - IDLE: expects dest = 0, any user; first accepted valid beat → STREAM, records pc.
  - STREAM: if previous dest = n_channels-1, expects dest = 0 and user ∈ {prev_pc, prev_pc+1} (wrap modulo 2^PC_WIDTH); else expects dest = prev_dest+1 and user = prev_pc.
  - STREAM: beat with opcode fcore_isa::STOP and dest = n_channels-1 → IDLE after acceptance.
  - FAULT: entered on any mismatch; offending beat dropped (not buffered); all further beats accepted and dropped (tready forced 1); fault = 1.
- fault_clear: in FAULT → IDLE next cycle, fault = 0; in other states ignored. Buffered beats are kept.
- fault entry while beats are buffered: buffered beats still drain normally.

## Timing
- Reset (reset = 0): all outputs 0, tready 0, buffers empty, state IDLE. tready rises on first clock edge after reset release.
- Latency: beat accepted at edge N presents on out_* with out_valid = 1 after edge N (one cycle).
- Throughput: one beat/cycle while out_ready = 1.
- Backpressure: out_ready low with OUT full → next beat into SKID; tready low from following cycle; zero beats lost.
- out_* stable while out_valid & ~out_ready.
- Fault asserts the cycle after the violating beat is accepted.
- Simultaneous fault_clear and violating beat in FAULT: clear wins, beat dropped.
- Reset mid-stream: buffers discarded, no program_done.

## Configuration
- FCORE_RX_SEQ_CHECK_EN defined: sequencer and fault logic as above.
- Undefined: no sequence check; fault tied 0, fault_clear ignored, all beats buffered; program_done still generated from STOP on channel n_channels-1.

## Test plan
- n_channels = 3, pcs 0,0,0,1,1,1 dest 0,1,2,0,1,2, out_ready = 1 -> six beats out, each one cycle after acceptance, fault = 0.
- Same stream, out_ready low for 4 cycles after beat 1 -> tready drops after SKID fills, beats 1–6 delivered in order, none lost.
- n_channels = 3, dest sequence 0,2 -> fault = 1 cycle after beat 2, beat 2 not output; subsequent beats dropped; fault_clear -> IDLE, stream from dest 0 resumes.
- n_channels = 2, pc jumps 3 → 5 at channel wrap -> fault; pc 4095 → 0 at wrap -> accepted.
- STOP opcode on dest = n_channels-1 -> program_done pulse on its transfer, next beat must be dest 0.
- n_channels = 0 -> all beats dest 0, accepted, pc advancing by 1 each beat.
